// File: rtl/rs_syndrome_x4.sv
// Reed-Solomon (255,239) syndrome calculator over GF(2^8)/0x11D, four bytes per clock, 64-word frames.
// Define RS_SYN_ERRCNT_EN to add a saturating 16-bit count of errored frames (err_cnt).

module gf256_const_mult #(
  parameter int EXP = 0
) (
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
  endfunction

  function automatic logic [7:0] gf_pow(input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < (e % 255); i++) r = xtime(r);
    return r;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] c);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Operand is a constant, so this folds down to a small XOR network.
  localparam logic [7:0] COEF = gf_pow(EXP);

  always_comb y = gf_mul(a, COEF);

endmodule

module rs_syndrome_x4 #(
  parameter int FCR = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         frame_start_in,
  input  logic [31:0]  din,
  output logic         syn_valid,
  output logic [127:0] syn,
`ifdef RS_SYN_ERRCNT_EN
  output logic         err_flag,
  output logic [15:0]  err_cnt
`else
  output logic         err_flag
`endif
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  logic [0:0]   state_reg;
  logic [5:0]   cnt_reg;
  logic [127:0] acc_reg;
  logic [127:0] acc_next;
  logic [127:0] syn_reg;
  logic         syn_valid_reg;
  logic         err_flag_reg;
  logic [7:0]   b0_eff;

  // A frame start restarts from zero and drops the pad byte of word 0.
  assign b0_eff = frame_start_in ? 8'h00 : din[31:24];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_syn
      localparam int K = FCR + gi;
      logic [7:0] acc_base;
      logic [7:0] m4;
      logic [7:0] m3;
      logic [7:0] m2;
      logic [7:0] m1;

      assign acc_base = frame_start_in ? 8'h00 : acc_reg[8*gi +: 8];

      gf256_const_mult #(.EXP(4*K)) u_m4 (.a(acc_base),   .y(m4));
      gf256_const_mult #(.EXP(3*K)) u_m3 (.a(b0_eff),     .y(m3));
      gf256_const_mult #(.EXP(2*K)) u_m2 (.a(din[23:16]), .y(m2));
      gf256_const_mult #(.EXP(K))   u_m1 (.a(din[15:8]),  .y(m1));

      assign acc_next[8*gi +: 8] = m4 ^ m3 ^ m2 ^ m1 ^ din[7:0];
    end
  endgenerate

`ifdef RS_SYN_ERRCNT_EN
  logic [15:0] err_cnt_reg;
  assign err_cnt = err_cnt_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 6'd0;
      acc_reg       <= '0;
      syn_reg       <= '0;
      syn_valid_reg <= 1'b0;
      err_flag_reg  <= 1'b0;
`ifdef RS_SYN_ERRCNT_EN
      err_cnt_reg   <= 16'd0;
`endif
    end else begin
      syn_valid_reg <= 1'b0;
      if (!en) begin
        state_reg <= ST_IDLE;
        cnt_reg   <= 6'd0;
        acc_reg   <= '0;
      end else if (frame_start_in) begin
        // Also covers a restart inside a frame, including on the word-63 slot.
        state_reg <= ST_ACCUM;
        cnt_reg   <= 6'd1;
        acc_reg   <= acc_next;
      end else if (state_reg == ST_ACCUM) begin
        if (cnt_reg == 6'd63) begin
          syn_reg       <= acc_next;
          err_flag_reg  <= |acc_next;
          syn_valid_reg <= 1'b1;
          state_reg     <= ST_IDLE;
          cnt_reg       <= 6'd0;
          acc_reg       <= '0;
`ifdef RS_SYN_ERRCNT_EN
          if ((|acc_next) && (err_cnt_reg != 16'hFFFF)) err_cnt_reg <= err_cnt_reg + 16'd1;
`endif
        end else begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + 6'd1;
        end
      end
    end
  end

  assign syn       = syn_reg;
  assign syn_valid = syn_valid_reg;
  assign err_flag  = err_flag_reg;

endmodule
